// File: rtl/mem_block_mover_pkg.sv
// Shared constants, state encoding and request payload for the data-memory block mover.
package mem_block_mover_pkg;

  localparam int unsigned MEM_DEPTH = 50;
  localparam int unsigned ADDR_W    = 6;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned SUM_W     = ADDR_W + 1;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic              mode;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [ADDR_W-1:0] len;
    logic [DATA_W-1:0] fill;
  } req_t;

endpackage

// File: rtl/mem_block_mover.sv
// Bus-master engine that copies (memmove-safe) or fills a byte range of the data memory.
module mem_block_mover
  import mem_block_mover_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic [DATA_W-1:0] fill_value,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            r_state, w_state_nxt;
  req_t              r_req, w_req_nxt;
  logic [ADDR_W-1:0] r_offset, w_offset_nxt;
  logic              r_desc, w_desc_nxt;
  logic              r_error_q, w_error_q_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_error, w_error_nxt;
  logic              r_mem_read, w_mem_read_nxt;
  logic              r_mem_write, w_mem_write_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;

  logic [SUM_W-1:0]  w_dst_end, w_src_end;
  logic              w_reject, w_start_desc, w_last;
  logic [ADDR_W-1:0] w_start_off, w_off_step;

  // Request decode on the raw inputs, used only at the acceptance edge
  assign w_dst_end    = {1'b0, dst_addr} + {1'b0, length};
  assign w_src_end    = {1'b0, src_addr} + {1'b0, length};
  assign w_reject     = (length != '0) &&
                        ((w_dst_end > SUM_W'(MEM_DEPTH)) ||
                         ((mode == MODE_COPY) && (w_src_end > SUM_W'(MEM_DEPTH))));
  assign w_start_desc = (mode == MODE_COPY) && (dst_addr > src_addr);
  assign w_start_off  = w_start_desc ? (length - ADDR_W'(1)) : '0;

  assign w_last     = r_desc ? (r_offset == '0) : (r_offset == (r_req.len - ADDR_W'(1)));
  assign w_off_step = r_desc ? (r_offset - ADDR_W'(1)) : (r_offset + ADDR_W'(1));

  // Next state; bus outputs are computed one cycle ahead and registered
  always_comb begin
    w_state_nxt     = r_state;
    w_req_nxt       = r_req;
    w_offset_nxt    = r_offset;
    w_desc_nxt      = r_desc;
    w_error_q_nxt   = r_error_q;
    w_busy_nxt      = 1'b0;
    w_done_nxt      = 1'b0;
    w_error_nxt     = 1'b0;
    w_mem_read_nxt  = 1'b0;
    w_mem_write_nxt = 1'b0;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_req_nxt.mode = mode;
          w_req_nxt.src  = src_addr;
          w_req_nxt.dst  = dst_addr;
          w_req_nxt.len  = length;
          w_req_nxt.fill = fill_value;
          w_offset_nxt   = w_start_off;
          w_desc_nxt     = w_start_desc;
          w_busy_nxt     = 1'b1;
          if ((length == '0) || w_reject) begin
            w_state_nxt   = S_DONE;
            w_error_q_nxt = w_reject;
            w_done_nxt    = 1'b1;
            w_error_nxt   = w_reject;
          end else if (mode == MODE_COPY) begin
            w_state_nxt    = S_READ;
            w_mem_read_nxt = 1'b1;
            w_mem_addr_nxt = src_addr + w_start_off;
          end else begin
            w_state_nxt     = S_WRITE;
            w_mem_write_nxt = 1'b1;
            w_mem_addr_nxt  = dst_addr + w_start_off;
            w_mem_wdata_nxt = fill_value;
          end
        end
      end
      S_READ: begin
        // The write-data register doubles as the copy buffer
        w_state_nxt     = S_WRITE;
        w_busy_nxt      = 1'b1;
        w_mem_write_nxt = 1'b1;
        w_mem_addr_nxt  = r_req.dst + r_offset;
        w_mem_wdata_nxt = mem_rdata;
      end
      S_WRITE: begin
        w_busy_nxt = 1'b1;
        if (w_last) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
          w_error_nxt = r_error_q;
        end else begin
          w_offset_nxt = w_off_step;
          if (r_req.mode == MODE_COPY) begin
            w_state_nxt    = S_READ;
            w_mem_read_nxt = 1'b1;
            w_mem_addr_nxt = r_req.src + w_off_step;
          end else begin
            w_mem_write_nxt = 1'b1;
            w_mem_addr_nxt  = r_req.dst + w_off_step;
            w_mem_wdata_nxt = r_req.fill;
          end
        end
      end
      S_DONE: begin
        w_state_nxt   = S_IDLE;
        w_error_q_nxt = 1'b0;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_req       <= '0;
      r_offset    <= '0;
      r_desc      <= 1'b0;
      r_error_q   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_req       <= w_req_nxt;
      r_offset    <= w_offset_nxt;
      r_desc      <= w_desc_nxt;
      r_error_q   <= w_error_q_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_error     <= w_error_nxt;
      r_mem_read  <= w_mem_read_nxt;
      r_mem_write <= w_mem_write_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule
